// File: rtl/ah_ddr2pl_reader.sv
// ah_ddr2pl_reader: AXI4 read master that streams a DDR ring into the PL.
// Define AH_DDR2PL_RRESP_CHECK_EN to discard and flag non-OKAY read beats.
module ah_ddr2pl_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           ddr_addr_low,
  input  logic [31:0]           ddr_addr_high,
  input  logic [31:0]           number_samples,
  output logic                  busy,
  output logic                  intr_done,
  output logic                  intr_error,
  output logic [31:0]           samples_read,
  output logic [31:0]           current_ddr_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [31:0]           m_axi_in_araddr,
  output logic [7:0]            m_axi_in_arlen,
  output logic [2:0]            m_axi_in_arsize,
  output logic [1:0]            m_axi_in_arburst,
  output logic                  m_axi_in_arvalid,
  input  logic                  m_axi_in_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_in_rdata,
  input  logic [1:0]            m_axi_in_rresp,
  input  logic                  m_axi_in_rlast,
  input  logic                  m_axi_in_rvalid,
  output logic                  m_axi_in_rready
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LBYTES = $clog2(NBYTES);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [31:0] BURST_W = 32'(BURST_LEN);
  localparam logic [32:0] SPAN_M1 = 33'(BURST_LEN * NBYTES - 1);
  localparam logic [CW-1:0] DEPTH_W = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_NEXT,
    S_DONE
  } state_t;

  state_t r_state;

  logic [31:0] r_low;
  logic [31:0] r_high;
  logic [31:0] r_addr;
  logic [31:0] r_remaining;
  logic [31:0] r_beats;
  logic [31:0] r_samples;
  logic        r_busy;
  logic        r_done;
  logic        r_abort;
  logic        r_stop;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;
  logic        r_arvalid;
  logic        r_rready;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic        w_beat;
  logic        w_err;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_stop_req;
  logic [31:0] w_free;
  logic [31:0] w_beats;
  logic [31:0] w_next_addr;
  logic [32:0] w_next_end;
  logic        w_wrap;

  assign w_beat = m_axi_in_rvalid && r_rready;

`ifdef AH_DDR2PL_RRESP_CHECK_EN
  logic r_err;

  assign w_err      = w_beat && (m_axi_in_rresp != 2'b00);
  assign intr_error = r_err;
`else
  logic w_unused_rresp;

  assign w_err          = 1'b0;
  assign w_unused_rresp = ^m_axi_in_rresp;
  assign intr_error     = 1'b0;
`endif

  assign w_push     = w_beat && !w_err;
  assign w_pop      = (r_count != '0) && data_ready;
  assign w_stop_req = r_abort || abort;
  assign w_flush    = (r_state == S_DONE) && w_stop_req;

  assign w_free  = 32'(DEPTH_W - r_count);
  assign w_beats = (r_remaining < BURST_W) ? r_remaining : BURST_W;

  assign w_next_addr = r_addr + (r_beats << LBYTES);
  assign w_next_end  = {1'b0, w_next_addr} + SPAN_M1;
  assign w_wrap      = w_next_end > {1'b0, r_high};

  // FIFO storage; pointers restart on reset or flush
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= m_axi_in_rdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Job sequencing: address phase, data phase, ring step, completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_low       <= '0;
      r_high      <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_samples   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_stop      <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
`ifdef AH_DDR2PL_RRESP_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_abort <= 1'b1;
      end
`ifdef AH_DDR2PL_RRESP_CHECK_EN
      r_err <= w_err;
      if (w_err) begin
        r_stop <= 1'b1;
      end
`endif
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_low       <= ddr_addr_low;
            r_high      <= ddr_addr_high;
            r_addr      <= ddr_addr_low;
            r_remaining <= number_samples;
            r_samples   <= '0;
            r_busy      <= 1'b1;
            r_abort     <= 1'b0;
            r_stop      <= 1'b0;
            if (number_samples == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (r_arvalid) begin
            if (m_axi_in_arready) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= S_DATA;
            end
          end else if (w_stop_req) begin
            r_state <= S_DONE;
          end else if (w_free >= w_beats) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_addr;
            r_arlen   <= 8'(w_beats - 32'd1);
            r_beats   <= w_beats;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_samples   <= r_samples + 32'd1;
            r_remaining <= r_remaining - 32'd1;
            if (m_axi_in_rlast) begin
              r_rready <= 1'b0;
              if ((r_remaining == 32'd1) || w_stop_req
                  || r_stop || w_err) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_NEXT;
              end
            end
          end
        end
        S_NEXT: begin
          if (w_wrap) begin
            r_addr <= r_low;
          end else begin
            r_addr <= w_next_addr;
          end
          if (w_stop_req) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_ADDR;
          end
        end
        S_DONE: begin
          if ((r_count == '0) || w_stop_req) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign intr_done        = r_done;
  assign samples_read     = r_samples;
  assign current_ddr_addr = r_addr;
  assign data_valid       = (r_count != '0);
  assign data_out         = data_valid ? r_mem[r_rd_ptr] : '0;
  assign m_axi_in_araddr  = r_araddr;
  assign m_axi_in_arlen   = r_arlen;
  assign m_axi_in_arsize  = 3'(LBYTES);
  assign m_axi_in_arburst = 2'b01;
  assign m_axi_in_arvalid = r_arvalid;
  assign m_axi_in_rready  = r_rready;

endmodule
